// File: rtl/apb_protocol_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_protocol_checker_if
// Brief    : APB4 bridge-to-peripheral bus bundle with master, slave and
//            passive monitor views.
// Revision : 1.0
// ============================================================================
interface apb_protocol_checker_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_SEL    = 4
);
  logic [NUM_SEL-1:0]    psel;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [2:0]            pprot;
  logic                  penable;
  logic                  pready;
  logic                  pslverr;
  logic [DATA_WIDTH-1:0] prdata;

  modport master (
    output psel, paddr, pwrite, pwdata, pstrb, pprot, penable,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  psel, paddr, pwrite, pwdata, pstrb, pprot, penable,
    output pready, pslverr, prdata
  );

  modport monitor (
    input psel, paddr, pwrite, pwdata, pstrb, pprot, penable,
    input pready, pslverr, prdata
  );
endinterface
`default_nettype wire

// File: rtl/apb_protocol_checker.sv
`default_nettype none
// ============================================================================
// Module   : apb_protocol_checker
// Brief    : Passive APB4 protocol checker: violation vectors, completed
//            transfer records, wait-state timeout and saturating statistics.
// Revision : 1.0
// ============================================================================
module apb_protocol_checker #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int NUM_SEL        = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 16,
  localparam int SEL_W         = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1,
  localparam int WAIT_W        = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  wire logic                 pclk,
  input  wire logic                 preset,
  apb_protocol_checker_if.monitor   bus,
  input  wire logic                 i_clr_counts,
  output logic                      o_err_valid,
  output logic [7:0]                o_err_vec,
  output logic                      o_xfer_done,
  output logic                      o_xfer_write,
  output logic                      o_xfer_slverr,
  output logic [SEL_W-1:0]          o_xfer_sel,
  output logic [WAIT_W-1:0]         o_xfer_waits,
  output logic [CNT_WIDTH-1:0]      o_xfer_count,
  output logic [CNT_WIDTH-1:0]      o_err_count,
  output logic                      o_busy
);

  localparam int c_ENABLE_NO_SEL = 0;
  localparam int c_MULTI_SEL     = 1;
  localparam int c_SETUP_SKIP    = 2;
  localparam int c_UNSTABLE      = 3;
  localparam int c_READY_INVALID = 4;
  localparam int c_TIMEOUT       = 5;
  localparam int c_ABORT         = 6;
  localparam int c_STRB_ON_READ  = 7;
  localparam logic [WAIT_W-1:0] c_WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t                r_state;
  logic [WAIT_W-1:0]     r_wait;
  logic [NUM_SEL-1:0]    r_snap_psel;
  logic [ADDR_WIDTH-1:0] r_snap_addr;
  logic                  r_snap_write;
  logic [DATA_WIDTH-1:0] r_snap_wdata;
  logic [STRB_WIDTH-1:0] r_snap_strb;
  logic [2:0]            r_snap_prot;

  logic                  w_sel;
  logic                  w_multi;
  logic                  w_access;
  logic                  w_setup;
  logic                  w_strb_read;
  logic                  w_snap_diff;
  logic [7:0]            w_vec;
  state_t                w_next_state;
  logic [WAIT_W-1:0]     w_next_wait;
  logic                  w_snap_load;
  logic                  w_done;
  logic                  w_done_write;
  logic [NUM_SEL-1:0]    w_done_psel;
  logic [WAIT_W-1:0]     w_done_waits;
  logic                  w_unused_prdata;

  assign w_sel           = |bus.psel;
  assign w_multi         = (bus.psel & (bus.psel - NUM_SEL'(1))) != '0;
  assign w_access        = w_sel & bus.penable;
  assign w_setup         = w_sel & ~bus.penable;
  assign w_strb_read     = ~bus.pwrite & (bus.pstrb != '0);
  assign w_unused_prdata = ^bus.prdata;
  assign w_snap_diff     = {bus.psel, bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb, bus.pprot}
                        != {r_snap_psel, r_snap_addr, r_snap_write, r_snap_wdata, r_snap_strb, r_snap_prot};

  // Under MULTI_SEL the record reports the lowest selected peripheral.
  function automatic logic [SEL_W-1:0] f_lowest(input logic [NUM_SEL-1:0] v);
    f_lowest = '0;
    for (int i = NUM_SEL - 1; i >= 0; i--) begin
      if (v[i]) f_lowest = SEL_W'(i);
    end
  endfunction

  always_comb begin
    w_vec        = '0;
    w_next_state = r_state;
    w_next_wait  = r_wait;
    w_snap_load  = 1'b0;
    w_done       = 1'b0;
    w_done_write = r_snap_write;
    w_done_psel  = r_snap_psel;
    w_done_waits = r_wait;
    w_vec[c_ENABLE_NO_SEL] = bus.penable & ~w_sel;
    w_vec[c_MULTI_SEL]     = w_multi;
    w_vec[c_READY_INVALID] = bus.pready & ~w_access;
    case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          w_snap_load  = 1'b1;
          w_next_wait  = '0;
          w_next_state = S_SETUP;
        end else if (w_access) begin
          w_vec[c_SETUP_SKIP]   = 1'b1;
          w_vec[c_STRB_ON_READ] = w_strb_read;
          if (bus.pready) begin
            w_done       = 1'b1;
            w_done_write = bus.pwrite;
            w_done_psel  = bus.psel;
            w_done_waits = '0;
          end else begin
            // Skipped setup: this access sample is the snapshot and the first wait.
            w_snap_load        = 1'b1;
            w_next_wait        = WAIT_W'(1);
            w_vec[c_TIMEOUT]   = (c_WAIT_MAX == WAIT_W'(1));
            w_next_state       = S_ACCESS;
          end
        end
      end
      S_SETUP, S_ACCESS: begin
        if (w_access) begin
          w_vec[c_UNSTABLE]     = w_snap_diff;
          w_vec[c_STRB_ON_READ] = w_strb_read;
          if (bus.pready) begin
            w_done       = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_next_state     = S_ACCESS;
            w_vec[c_TIMEOUT] = (r_wait == c_WAIT_MAX - WAIT_W'(1));
            if (r_wait != c_WAIT_MAX) w_next_wait = r_wait + WAIT_W'(1);
          end
        end else begin
          w_vec[c_ABORT] = 1'b1;
          if (w_setup) begin
            w_snap_load  = 1'b1;
            w_next_wait  = '0;
            w_next_state = S_SETUP;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state       <= S_IDLE;
      r_wait        <= '0;
      r_snap_psel   <= '0;
      r_snap_addr   <= '0;
      r_snap_write  <= 1'b0;
      r_snap_wdata  <= '0;
      r_snap_strb   <= '0;
      r_snap_prot   <= '0;
      o_err_valid   <= 1'b0;
      o_err_vec     <= '0;
      o_xfer_done   <= 1'b0;
      o_xfer_write  <= 1'b0;
      o_xfer_slverr <= 1'b0;
      o_xfer_sel    <= '0;
      o_xfer_waits  <= '0;
      o_xfer_count  <= '0;
      o_err_count   <= '0;
      o_busy        <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_wait      <= w_next_wait;
      o_busy      <= (w_next_state != S_IDLE);
      o_err_valid <= |w_vec;
      o_err_vec   <= w_vec;
      o_xfer_done <= w_done;
      if (w_snap_load) begin
        r_snap_psel  <= bus.psel;
        r_snap_addr  <= bus.paddr;
        r_snap_write <= bus.pwrite;
        r_snap_wdata <= bus.pwdata;
        r_snap_strb  <= bus.pstrb;
        r_snap_prot  <= bus.pprot;
      end
      if (w_done) begin
        o_xfer_write  <= w_done_write;
        o_xfer_slverr <= bus.pslverr;
        o_xfer_sel    <= f_lowest(w_done_psel);
        o_xfer_waits  <= w_done_waits;
      end
      if (i_clr_counts) begin
        o_xfer_count <= '0;
        o_err_count  <= '0;
      end else begin
        if (w_done && (o_xfer_count != '1)) o_xfer_count <= o_xfer_count + CNT_WIDTH'(1);
        if ((|w_vec) && (o_err_count != '1)) o_err_count <= o_err_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_protocol_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_protocol_checker
// Brief    : Directed scoreboard bench for apb_protocol_checker.
// Revision : 1.0
// ============================================================================
module tb_apb_protocol_checker;

  logic       clk = 1'b0;
  logic       preset = 1'b1;
  logic       i_clr_counts = 1'b0;
  logic       o_err_valid, o_xfer_done, o_xfer_write, o_xfer_slverr, o_busy;
  logic [7:0] o_err_vec;
  logic [1:0] o_xfer_sel;
  logic [2:0] o_xfer_waits;
  logic [3:0] o_xfer_count, o_err_count;

  int total = 0;
  int bad   = 0;
  int nout  = 0;

  typedef struct packed {
    logic       ev;
    logic [7:0] vec;
    logic       xd;
    logic       wr;
    logic       se;
    logic [1:0] sel;
    logic [2:0] waits;
    logic [3:0] ec;
    logic [3:0] xc;
  } exp_t;

  exp_t q[$];
  exp_t m_act, m_exp;

  apb_protocol_checker_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SEL(4)) bus ();

  apb_protocol_checker #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SEL(4),
    .TIMEOUT_CYCLES(4), .CNT_WIDTH(4)
  ) dut (
    .pclk          (clk),
    .preset        (preset),
    .bus           (bus.monitor),
    .i_clr_counts  (i_clr_counts),
    .o_err_valid   (o_err_valid),
    .o_err_vec     (o_err_vec),
    .o_xfer_done   (o_xfer_done),
    .o_xfer_write  (o_xfer_write),
    .o_xfer_slverr (o_xfer_slverr),
    .o_xfer_sel    (o_xfer_sel),
    .o_xfer_waits  (o_xfer_waits),
    .o_xfer_count  (o_xfer_count),
    .o_err_count   (o_err_count),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!preset && (o_err_valid || o_xfer_done)) begin
      nout++;
      total++;
      m_act.ev    = o_err_valid;
      m_act.vec   = o_err_vec;
      m_act.xd    = o_xfer_done;
      m_act.wr    = o_xfer_done ? o_xfer_write  : 1'b0;
      m_act.se    = o_xfer_done ? o_xfer_slverr : 1'b0;
      m_act.sel   = o_xfer_done ? o_xfer_sel    : 2'd0;
      m_act.waits = o_xfer_done ? o_xfer_waits  : 3'd0;
      m_act.ec    = o_err_count;
      m_act.xc    = o_xfer_count;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out#%0d got ev=%b vec=%h xd=%b required none", nout, m_act.ev, m_act.vec, m_act.xd);
      end else begin
        m_exp = q.pop_front();
        if (m_act !== m_exp) begin
          bad++;
          $display("FAIL out#%0d got ev=%b vec=%h xd=%b wr=%b se=%b sel=%0d w=%0d ec=%0d xc=%0d required ev=%b vec=%h xd=%b wr=%b se=%b sel=%0d w=%0d ec=%0d xc=%0d",
                   nout, m_act.ev, m_act.vec, m_act.xd, m_act.wr, m_act.se, m_act.sel, m_act.waits, m_act.ec, m_act.xc,
                   m_exp.ev, m_exp.vec, m_exp.xd, m_exp.wr, m_exp.se, m_exp.sel, m_exp.waits, m_exp.ec, m_exp.xc);
        end
      end
    end
  end

  task automatic push(input logic [7:0] vec, input logic xd, input logic wr, input logic se,
                      input logic [1:0] sel, input logic [2:0] w, input logic [3:0] ec, input logic [3:0] xc);
    exp_t e;
    e.ev = (vec != 8'h00); e.vec = vec; e.xd = xd; e.wr = wr; e.se = se;
    e.sel = sel; e.waits = w; e.ec = ec; e.xc = xc;
    q.push_back(e);
  endtask

  task automatic cyc(input logic [3:0] sel, input logic en, input logic rdy, input logic [31:0] addr,
                     input logic wr, input logic [3:0] strb, input logic slv);
    bus.psel = sel; bus.penable = en; bus.pready = rdy; bus.paddr = addr;
    bus.pwrite = wr; bus.pstrb = strb; bus.pslverr = slv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.psel = '0; bus.penable = 1'b0; bus.pready = 1'b0; bus.paddr = '0; bus.pwrite = 1'b0;
    bus.pstrb = '0; bus.pslverr = 1'b0; bus.pprot = 3'd0; bus.pwdata = 32'hA5A5_0001;
    bus.prdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {17'd0, o_err_valid, o_xfer_done, o_busy, o_err_vec, o_err_count}, 32'd0);
    chk("reset_xcount", {28'd0, o_xfer_count}, 32'd0);
    preset = 1'b0;
    idle();

    // Write to peripheral 1, two wait states.
    cyc(4'b0010, 1'b0, 1'b0, 32'h40, 1'b1, 4'hF, 1'b0);
    cyc(4'b0010, 1'b1, 1'b0, 32'h40, 1'b1, 4'hF, 1'b0);
    chk("busy_in_access", {31'd0, o_busy}, 32'd1);
    cyc(4'b0010, 1'b1, 1'b0, 32'h40, 1'b1, 4'hF, 1'b0);
    push(8'h00, 1, 1, 0, 2'd1, 3'd2, 4'd0, 4'd1);
    cyc(4'b0010, 1'b1, 1'b1, 32'h40, 1'b1, 4'hF, 1'b0);
    idle();

    // Address moves during a wait state.
    cyc(4'b0010, 1'b0, 1'b0, 32'h40, 1'b1, 4'hF, 1'b0);
    cyc(4'b0010, 1'b1, 1'b0, 32'h40, 1'b1, 4'hF, 1'b0);
    push(8'h08, 0, 0, 0, 2'd0, 3'd0, 4'd1, 4'd1);
    cyc(4'b0010, 1'b1, 1'b0, 32'h44, 1'b1, 4'hF, 1'b0);
    push(8'h00, 1, 1, 0, 2'd1, 3'd2, 4'd1, 4'd2);
    cyc(4'b0010, 1'b1, 1'b1, 32'h40, 1'b1, 4'hF, 1'b0);

    // Back-to-back read with six wait states and slave error.
    cyc(4'b0001, 1'b0, 1'b0, 32'h10, 1'b0, 4'h0, 1'b0);
    repeat (3) cyc(4'b0001, 1'b1, 1'b0, 32'h10, 1'b0, 4'h0, 1'b0);
    push(8'h20, 0, 0, 0, 2'd0, 3'd0, 4'd2, 4'd2);
    cyc(4'b0001, 1'b1, 1'b0, 32'h10, 1'b0, 4'h0, 1'b0);
    repeat (2) cyc(4'b0001, 1'b1, 1'b0, 32'h10, 1'b0, 4'h0, 1'b0);
    push(8'h00, 1, 0, 1, 2'd0, 3'd4, 4'd2, 4'd3);
    cyc(4'b0001, 1'b1, 1'b1, 32'h10, 1'b0, 4'h0, 1'b1);
    idle();

    // Multi-select access with no setup, read with strobes.
    push(8'h86, 1, 0, 0, 2'd0, 3'd0, 4'd3, 4'd4);
    cyc(4'b0101, 1'b1, 1'b1, 32'h20, 1'b0, 4'hF, 1'b0);
    idle();

    // Abort mid-access, then pready alone in IDLE.
    cyc(4'b1000, 1'b0, 1'b0, 32'h8, 1'b1, 4'hF, 1'b0);
    cyc(4'b1000, 1'b1, 1'b0, 32'h8, 1'b1, 4'hF, 1'b0);
    chk("busy_before_abort", {31'd0, o_busy}, 32'd1);
    push(8'h40, 0, 0, 0, 2'd0, 3'd0, 4'd4, 4'd4);
    cyc(4'b0000, 1'b0, 1'b0, 32'h8, 1'b1, 4'hF, 1'b0);
    chk("busy_after_abort", {31'd0, o_busy}, 32'd0);
    push(8'h10, 0, 0, 0, 2'd0, 3'd0, 4'd5, 4'd4);
    cyc(4'b0000, 1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 1'b0);

    // Zero-wait write to peripheral 2.
    cyc(4'b0100, 1'b0, 1'b0, 32'h30, 1'b1, 4'hF, 1'b0);
    push(8'h00, 1, 1, 0, 2'd2, 3'd0, 4'd5, 4'd5);
    cyc(4'b0100, 1'b1, 1'b1, 32'h30, 1'b1, 4'hF, 1'b0);
    idle();

    // Drive err_count into saturation, then clear alongside a new error.
    for (int i = 0; i < 11; i++) begin
      push(8'h10, 0, 0, 0, 2'd0, 3'd0, (6 + i > 15) ? 4'd15 : 4'(6 + i), 4'd5);
      cyc(4'b0000, 1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 1'b0);
    end
    i_clr_counts = 1'b1;
    push(8'h10, 0, 0, 0, 2'd0, 3'd0, 4'd0, 4'd0);
    cyc(4'b0000, 1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 1'b0);
    i_clr_counts = 1'b0;
    chk("xcount_cleared", {28'd0, o_xfer_count}, 32'd0);

    // penable without any select.
    push(8'h01, 0, 0, 0, 2'd0, 3'd0, 4'd1, 4'd0);
    cyc(4'b0000, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
    idle();

    // Reset mid-access; bus still in access on the first post-reset sample.
    cyc(4'b0010, 1'b0, 1'b0, 32'h50, 1'b1, 4'hF, 1'b0);
    cyc(4'b0010, 1'b1, 1'b0, 32'h50, 1'b1, 4'hF, 1'b0);
    preset = 1'b1;
    cyc(4'b0010, 1'b1, 1'b0, 32'h50, 1'b1, 4'hF, 1'b0);
    chk("midreset_outputs", {17'd0, o_err_valid, o_xfer_done, o_busy, o_err_vec, o_err_count}, 32'd0);
    chk("midreset_record", {20'd0, o_xfer_write, o_xfer_slverr, o_xfer_sel, o_xfer_waits, o_xfer_count}, 32'd0);
    preset = 1'b0;
    push(8'h04, 1, 1, 0, 2'd1, 3'd0, 4'd1, 4'd1);
    cyc(4'b0010, 1'b1, 1'b1, 32'h50, 1'b1, 4'hF, 1'b0);
    repeat (3) idle();

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
